pe_weight_loader: RTL and testbench
===================================

Name: pe_weight_loader

Overview:
- Sequences weight download from a shared streaming source into one of pNUM_PE convolution PEs, using each PE's load_weight / weight_addr / weight_data load port.
- Software-side control issues one load job at a time: target PE, base address and word count. The block then drains exactly that many stream words into the selected PE and pulses done.
- Sits between the host/DMA weight stream and the array of PE instances. It is the only driver of their weight-load ports.

Parameters:
- pWEIGHT_DATA_WIDTH, 64: width of one weight word (stream and PE load port).
- pNUM_PE, 4: number of PEs sharing the weight stream.
- pCOUNT_WIDTH, 16: width of the job word count.
- pADDR_STEP, 1: weight_addr increment per accepted word.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  job request; sampled only in IDLE.
- cfg_pe_sel  in  $clog2(pNUM_PE)  target PE index, sampled with start.
- cfg_base_addr  in  32  address of the first word, sampled with start.
- cfg_word_count  in  pCOUNT_WIDTH  number of words in the job, sampled with start.
- abort  in  1  cancel the current job.
- pe_busy  in  pNUM_PE  per-PE busy (PE not ready, i.e. !pe_ready); loading a busy PE is forbidden.
- s_valid  in  1  weight stream word valid.
- s_data  in  pWEIGHT_DATA_WIDTH  weight stream word.
- s_ready  out  1  weight stream ready.
- load_weight  out  pNUM_PE  one-hot write strobe per PE.
- weight_addr  out  32  shared PE weight address.
- weight_data  out  pWEIGHT_DATA_WIDTH  shared PE weight data.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a job completes.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- words_loaded  out  pCOUNT_WIDTH  words written in the current or last job.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0.
- FSM states: IDLE, LOAD, DONE.

IDLE:
- s_ready = 0.
- start with pe_busy[cfg_pe_sel] = 1 → stay IDLE; cfg_err pulses on the next cycle.
- start with cfg_pe_sel >= pNUM_PE → stay IDLE; cfg_err pulses on the next cycle.
- Valid start with cfg_word_count = 0 → go to DONE; no load strobes.
- Other valid start → latch sel, base and count; clear words_loaded; go to LOAD.

LOAD:
- s_ready = 1 combinationally while in LOAD and remaining count > 0.
- Handshake: a transfer occurs on s_valid && s_ready. s_valid may drop at any time; stalls insert no strobes.
- Each transfer registers its outputs one cycle later:
  - load_weight = one-hot(sel) for exactly one cycle;
  - weight_data = s_data;
  - weight_addr = base + n*pADDR_STEP, where n is 0-based;
  - words_loaded increments by 1.
- Back-to-back transfers produce back-to-back strobes with consecutive addresses.
- When the transfer that reaches count is accepted, go to DONE the next cycle; s_ready is low from that cycle on.
- abort in LOAD has priority over a same-cycle transfer: that word is not written, go to IDLE, no done. words_loaded keeps its value.

DONE:
- done = 1 for one cycle; go to IDLE.
- The final load_weight strobe and done are asserted in the same cycle.

General rules:
- weight_addr and weight_data hold their last value when no strobe is active.
- start outside IDLE is ignored with no cfg_err.
- pe_busy is checked only at start; a PE going busy mid-job does not interrupt the job.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32.
- Count compare uses pCOUNT_WIDTH bits; max job = 2^pCOUNT_WIDTH − 1 words.
- rst mid-job returns immediately to the reset state; any pending strobe is dropped.

Decomposition:
- Shared package pe_pkg:
  - state enum typedef (IDLE/LOAD/DONE);
  - localparam for the default weight base address;
  - weight word width constant.
- No sub-module required. The one-hot decoder is inline.
- The block is instantiated once per layer group, with load_weight[i] wired to PE i.

Test Plan:
- Basic job: start, sel=2, base=0x1000, count=4, s_valid held high → load_weight=4'b0100 on 4 consecutive cycles, addr 0x1000..0x1003, data matches the stream in order, done on the cycle of the 4th strobe, words_loaded=4, busy low the cycle after done.
- Stall: same job with s_valid toggling 1,0,0,1,1,0,1 → exactly 4 strobes, one per accepted word, addresses contiguous, no strobe during gaps.
- Reject: pe_busy=4'b0010, start with sel=1 → cfg_err pulse one cycle later, busy stays 0, no strobes, s_ready stays 0.
- Zero count: start, count=0 → done pulses 2 cycles after start, no load_weight, words_loaded=0.
- Abort: count=8, abort asserted together with the 3rd transfer → exactly 2 strobes, no done, busy falls the next cycle, words_loaded=2; a subsequent job starts cleanly at its base address.
- Wrap and reset: base=0xFFFF_FFFE, count=3 → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0. Separate run: rst asserted mid-LOAD → all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE weight-load path.
package pe_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_e;

  localparam logic [31:0] WeightBaseDefault = 32'h0000_0000;
  localparam int unsigned WeightWordWidth   = 64;

endpackage

// File: rtl/pe_weight_loader.sv
// Streams one load job of weight words into a selected PE through its load port,
// strobing load_weight one-hot per accepted word and pulsing done at job end.
module pe_weight_loader
  import pe_pkg::*;
#(
  parameter int unsigned pWEIGHT_DATA_WIDTH = WeightWordWidth,
  parameter int unsigned pNUM_PE            = 4,
  parameter int unsigned pCOUNT_WIDTH       = 16,
  parameter int unsigned pADDR_STEP         = 1,
  localparam int unsigned SelW              = (pNUM_PE > 1) ? $clog2(pNUM_PE) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [SelW-1:0]               cfg_pe_sel,
  input  logic [31:0]                   cfg_base_addr,
  input  logic [pCOUNT_WIDTH-1:0]       cfg_word_count,
  input  logic                          abort,
  input  logic [pNUM_PE-1:0]            pe_busy,
  input  logic                          s_valid,
  input  logic [pWEIGHT_DATA_WIDTH-1:0] s_data,
  output logic                          s_ready,
  output logic [pNUM_PE-1:0]            load_weight,
  output logic [31:0]                   weight_addr,
  output logic [pWEIGHT_DATA_WIDTH-1:0] weight_data,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  output logic [pCOUNT_WIDTH-1:0]       words_loaded
);

  localparam logic [31:0]             AddrStep = 32'(pADDR_STEP);
  localparam logic [pCOUNT_WIDTH-1:0] CountOne = pCOUNT_WIDTH'(1);

  state_e                          state_q;
  logic [SelW-1:0]                 sel_q;
  logic [31:0]                     next_addr_q;
  logic [pCOUNT_WIDTH-1:0]         count_q;
  logic [pCOUNT_WIDTH-1:0]         words_q;
  logic                            zero_job_q;
  logic [pNUM_PE-1:0]              load_weight_q;
  logic [31:0]                     weight_addr_q;
  logic [pWEIGHT_DATA_WIDTH-1:0]   weight_data_q;
  logic                            done_q;
  logic                            cfg_err_q;

  logic                            sel_in_range;
  logic                            sel_pe_busy;
  logic                            start_ok;
  logic                            ready_w;
  logic                            xfer;
  logic                            last_xfer;
  logic [pNUM_PE-1:0]              sel_onehot;

  always_comb begin
    sel_in_range = 32'(cfg_pe_sel) < pNUM_PE;
    sel_pe_busy  = 1'b0;
    if (sel_in_range) begin
      sel_pe_busy = pe_busy[cfg_pe_sel];
    end
    start_ok = sel_in_range && !sel_pe_busy;

    ready_w   = (state_q == StLoad) && (words_q != count_q);
    // Abort wins over a same-cycle handshake: that word is never written.
    xfer      = s_valid && ready_w && !abort;
    last_xfer = xfer && ((words_q + CountOne) == count_q);

    sel_onehot        = '0;
    sel_onehot[sel_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      next_addr_q   <= WeightBaseDefault;
      count_q       <= '0;
      words_q       <= '0;
      zero_job_q    <= 1'b0;
      load_weight_q <= '0;
      weight_addr_q <= '0;
      weight_data_q <= '0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      load_weight_q <= '0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (!start_ok) begin
              cfg_err_q <= 1'b1;
            end else begin
              sel_q       <= cfg_pe_sel;
              next_addr_q <= cfg_base_addr;
              count_q     <= cfg_word_count;
              words_q     <= '0;
              zero_job_q  <= (cfg_word_count == '0);
              state_q     <= (cfg_word_count == '0) ? StDone : StLoad;
            end
          end
        end
        StLoad: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (xfer) begin
            load_weight_q <= sel_onehot;
            weight_addr_q <= next_addr_q;
            weight_data_q <= s_data;
            words_q       <= words_q + CountOne;
            next_addr_q   <= next_addr_q + AddrStep;
            if (last_xfer) begin
              // done rides with the final strobe; DONE then lasts that one cycle.
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          // Empty jobs never strobed, so their done is raised on leaving DONE.
          done_q  <= zero_job_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_ready      = ready_w;
  assign load_weight  = load_weight_q;
  assign weight_addr  = weight_addr_q;
  assign weight_data  = weight_data_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_pe_weight_loader.sv
// Directed bench: strobes are scoreboarded against a queue filled as words are driven.
module tb_pe_weight_loader;

  localparam int unsigned DW = 64;
  localparam int unsigned NP = 4;
  localparam int unsigned CW = 16;

  typedef struct {
    logic [NP-1:0] lw;
    logic [31:0]   addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    cfg_pe_sel;
  logic [31:0]   cfg_base_addr;
  logic [CW-1:0] cfg_word_count;
  logic          abort;
  logic [NP-1:0] pe_busy;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [NP-1:0] load_weight;
  logic [31:0]   weight_addr;
  logic [DW-1:0] weight_data;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [CW-1:0] words_loaded;

  int   total = 0;
  int   bad   = 0;
  int   nstrobe = 0;
  exp_t sb[$];
  logic [NP-1:0] m_lw;
  logic [31:0]   m_addr;

  pe_weight_loader #(
    .pWEIGHT_DATA_WIDTH(DW),
    .pNUM_PE(NP),
    .pCOUNT_WIDTH(CW),
    .pADDR_STEP(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cfg_pe_sel(cfg_pe_sel),
    .cfg_base_addr(cfg_base_addr),
    .cfg_word_count(cfg_word_count),
    .abort(abort),
    .pe_busy(pe_busy),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .load_weight(load_weight),
    .weight_addr(weight_addr),
    .weight_data(weight_data),
    .busy(busy),
    .done(done),
    .cfg_err(cfg_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every nonzero load_weight must match the head of the scoreboard.
  always @(negedge clk) begin
    if (load_weight !== '0) begin
      nstrobe++;
      if (sb.size() == 0) begin
        check("unexpected_strobe", 64'(load_weight), 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_lw", 64'(load_weight), 64'(e.lw));
        check("strobe_addr", 64'(weight_addr), 64'(e.addr));
        check("strobe_data", weight_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] sel, input logic [31:0] base,
                           input logic [CW-1:0] cnt);
    start          = 1'b1;
    cfg_pe_sel     = sel;
    cfg_base_addr  = base;
    cfg_word_count = cnt;
    m_lw           = '0;
    m_lw[sel]      = 1'b1;
    m_addr         = base;
    tick();
    start = 1'b0;
  endtask

  // Drive one stream cycle; a valid word is expected to be accepted and strobed.
  task automatic xfer(input logic v, input logic [DW-1:0] d);
    exp_t e;
    s_valid = v;
    s_data  = d;
    if (v) begin
      e.lw   = m_lw;
      e.addr = m_addr;
      e.data = d;
      sb.push_back(e);
      m_addr = m_addr + 32'd1;
    end
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] stall_pat;
    rst = 1'b1; start = 1'b0; cfg_pe_sel = '0; cfg_base_addr = '0; cfg_word_count = '0;
    abort = 1'b0; pe_busy = '0; s_valid = 1'b0; s_data = '0;
    m_lw = '0; m_addr = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_sready", 64'(s_ready), 64'h0);
    check("rst_lw", 64'(load_weight), 64'h0);
    check("rst_addr", 64'(weight_addr), 64'h0);
    check("rst_data", weight_data, 64'h0);
    check("rst_done_err", {62'h0, done, cfg_err}, 64'h0);
    check("rst_words", 64'(words_loaded), 64'h0);

    // Basic job, s_valid held high
    start_job(2'd2, 32'h1000, 16'd4);
    check("basic_busy", 64'(busy), 64'h1);
    check("basic_sready", 64'(s_ready), 64'h1);
    for (int i = 0; i < 4; i++) begin
      check("basic_nodone_early", 64'(done), 64'h0);
      xfer(1'b1, 64'hA000_0000_0000_0000 + 64'(i));
    end
    check("basic_done", 64'(done), 64'h1);
    check("basic_last_lw", 64'(load_weight), 64'h4);
    check("basic_last_addr", 64'(weight_addr), 64'h1003);
    check("basic_words", 64'(words_loaded), 64'd4);
    check("basic_sready_off", 64'(s_ready), 64'h0);
    tick();
    check("basic_busy_off", 64'(busy), 64'h0);
    check("basic_done_off", 64'(done), 64'h0);
    check("basic_addr_hold", 64'(weight_addr), 64'h1003);

    // Stall pattern 1,0,0,1,1,0,1
    stall_pat = 7'b1011001;
    start_job(2'd2, 32'h2000, 16'd4);
    for (int i = 0; i < 7; i++) begin
      xfer(stall_pat[i], {$urandom, $urandom});
      if (i < 6) check("stall_nodone", 64'(done), 64'h0);
    end
    check("stall_done", 64'(done), 64'h1);
    check("stall_words", 64'(words_loaded), 64'd4);
    tick();

    // Reject: start on a busy PE
    pe_busy = 4'b0010;
    start_job(2'd1, 32'h3000, 16'd5);
    check("rej_cfg_err", 64'(cfg_err), 64'h1);
    check("rej_busy", 64'(busy), 64'h0);
    check("rej_sready", 64'(s_ready), 64'h0);
    tick();
    check("rej_cfg_err_pulse", 64'(cfg_err), 64'h0);
    check("rej_busy2", 64'(busy), 64'h0);
    pe_busy = '0;

    // Zero-count job
    start_job(2'd3, 32'h3000, 16'd0);
    check("zero_busy", 64'(busy), 64'h1);
    check("zero_done_early", 64'(done), 64'h0);
    tick();
    check("zero_done", 64'(done), 64'h1);
    check("zero_words", 64'(words_loaded), 64'h0);
    tick();
    check("zero_done_off", 64'(done), 64'h0);

    // Abort together with the 3rd transfer
    start_job(2'd0, 32'h3000, 16'd8);
    xfer(1'b1, 64'h1111);
    xfer(1'b1, 64'h2222);
    s_valid = 1'b1; s_data = 64'h3333; abort = 1'b1;
    tick();
    s_valid = 1'b0; abort = 1'b0;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    check("abort_lw", 64'(load_weight), 64'h0);
    check("abort_words", 64'(words_loaded), 64'd2);
    tick();
    start_job(2'd3, 32'h4000, 16'd1);
    xfer(1'b1, 64'h4444);
    check("post_abort_done", 64'(done), 64'h1);
    check("post_abort_addr", 64'(weight_addr), 64'h4000);
    check("post_abort_words", 64'(words_loaded), 64'd1);
    tick();

    // Address wrap
    start_job(2'd1, 32'hFFFF_FFFE, 16'd3);
    for (int i = 0; i < 3; i++) xfer(1'b1, 64'hBEEF_0000 + 64'(i));
    check("wrap_done", 64'(done), 64'h1);
    check("wrap_addr", 64'(weight_addr), 64'h0);
    tick();

    // Reset mid-job: pending word is dropped
    start_job(2'd2, 32'h5000, 16'd5);
    xfer(1'b1, 64'h5555);
    xfer(1'b1, 64'h6666);
    s_valid = 1'b1; s_data = 64'h7777; rst = 1'b1;
    tick();
    s_valid = 1'b0;
    check("mrst_lw", 64'(load_weight), 64'h0);
    check("mrst_busy", 64'(busy), 64'h0);
    check("mrst_sready", 64'(s_ready), 64'h0);
    check("mrst_addr", 64'(weight_addr), 64'h0);
    check("mrst_data", weight_data, 64'h0);
    check("mrst_words", 64'(words_loaded), 64'h0);
    check("mrst_done_err", {62'h0, done, cfg_err}, 64'h0);
    rst = 1'b0;
    tick(); tick();
    check("mrst_busy2", 64'(busy), 64'h0);

    check("sb_empty", 64'(sb.size()), 64'h0);
    check("strobe_count", 64'(nstrobe), 64'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
